// File: rtl/pe_feeder_pkg.sv
// Shared types and constants for the PE operand feeder: sequencer states,
// a constant-function log2 helper and the FP32 encoding of 1.0.
package pe_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    localparam int MAX_K_DEFAULT  = 16;
    localparam int ADDR_W_DEFAULT = clog2(MAX_K_DEFAULT);

    localparam logic [31:0] FP32_ONE = 32'h3F80_0000;

endpackage

// File: rtl/operand_regfile.sv
// Operand buffer: one synchronous write port, one combinational read port.
// Storage is deliberately not reset; entries must be written before use.
module operand_regfile
    import pe_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = MAX_K_DEFAULT,
    parameter int ADDR_W     = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Store one operand per write strobe.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/pe_operand_feeder.sv
// Transmit-side sequencer for one accumulating FP32 PE without input FIFO.
// Buffers one A-row and one B-column, streams them as a gap-free framed
// burst, then waits (bounded) for the PE result and reports done or err.
module pe_operand_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int MAX_K      = MAX_K_DEFAULT,
    parameter int ADDR_W     = clog2(MAX_K),
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W:0]       k_len,
    input  logic                  go,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ACC_WIDTH-1:0]  result,
    output logic                  pe_start,
    output logic                  pe_valid_in,
    output logic                  pe_last,
    output logic [DATA_WIDTH-1:0] pe_a,
    output logic [DATA_WIDTH-1:0] pe_b,
    input  logic [ACC_WIDTH-1:0]  pe_c,
    input  logic                  pe_output_valid
);

    localparam int TMR_W = clog2(TIMEOUT + 1);

    state_t                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_idx, w_idx_nxt;      // index of the next beat to load
    logic [ADDR_W:0]       r_k, w_k_nxt;
    logic [TMR_W-1:0]      r_tmr, w_tmr_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_err, w_err_nxt;
    logic [ACC_WIDTH-1:0]  r_result, w_result_nxt;
    logic                  r_pe_start, w_pe_start_nxt;
    logic                  r_pe_valid, w_pe_valid_nxt;
    logic                  r_pe_last, w_pe_last_nxt;
    logic [DATA_WIDTH-1:0] r_pe_a, w_pe_a_nxt;
    logic [DATA_WIDTH-1:0] r_pe_b, w_pe_b_nxt;

    logic                  w_wr_accept, w_wr_a, w_wr_b;
    logic [ADDR_W-1:0]     w_rd_addr;
    logic [DATA_WIDTH-1:0] w_rf_a, w_rf_b, w_op_a, w_op_b;
    logic                  w_k_legal;
    logic [ADDR_W:0]       w_k_last;

    assign w_wr_accept = wr_en && (r_state == IDLE);
    assign w_wr_a      = w_wr_accept && !wr_sel;
    assign w_wr_b      = w_wr_accept &&  wr_sel;

    // Beat 0 is loaded on the go edge, so IDLE always reads entry 0.
    assign w_rd_addr   = (r_state == IDLE) ? '0 : r_idx;

    operand_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_K),
        .ADDR_W     (ADDR_W)
    ) u_rf_a (
        .clk       (clk),
        .i_wr_en   (w_wr_a),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rf_a)
    );

    operand_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_K),
        .ADDR_W     (ADDR_W)
    ) u_rf_b (
        .clk       (clk),
        .i_wr_en   (w_wr_b),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rf_b)
    );

    // A write landing on the same edge as go must be seen by beat 0.
    assign w_op_a = (w_wr_a && (wr_addr == w_rd_addr)) ? wr_data : w_rf_a;
    assign w_op_b = (w_wr_b && (wr_addr == w_rd_addr)) ? wr_data : w_rf_b;

    assign w_k_legal = (k_len != '0) && (k_len <= (ADDR_W + 1)'(MAX_K));
    assign w_k_last  = r_k - (ADDR_W + 1)'(1);

    // Next-state and next-output decode; registered outputs default to idle values.
    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_k_nxt        = r_k;
        w_tmr_nxt      = r_tmr;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_result_nxt   = r_result;
        w_pe_start_nxt = 1'b0;
        w_pe_valid_nxt = 1'b0;
        w_pe_last_nxt  = 1'b0;
        w_pe_a_nxt     = '0;
        w_pe_b_nxt     = '0;

        case (r_state)
            IDLE: begin
                if (go) begin
                    if (w_k_legal) begin
                        w_state_nxt    = STREAM;
                        w_k_nxt        = k_len;
                        w_idx_nxt      = ADDR_W'(1);
                        w_pe_valid_nxt = 1'b1;
                        w_pe_start_nxt = 1'b1;
                        w_pe_last_nxt  = (k_len == (ADDR_W + 1)'(1));
                        w_pe_a_nxt     = w_op_a;
                        w_pe_b_nxt     = w_op_b;
                    end else begin
                        w_err_nxt      = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (r_pe_last) begin
                    w_state_nxt    = WAIT;
                    w_tmr_nxt      = '0;
                end else begin
                    w_pe_valid_nxt = 1'b1;
                    w_pe_last_nxt  = ({1'b0, r_idx} == w_k_last);
                    w_pe_a_nxt     = w_op_a;
                    w_pe_b_nxt     = w_op_b;
                    w_idx_nxt      = r_idx + ADDR_W'(1);
                end
            end
            WAIT: begin
                if (pe_output_valid) begin
                    w_result_nxt = pe_c;
                    w_done_nxt   = 1'b1;
                    w_state_nxt  = IDLE;
                end else if (r_tmr == TMR_W'(TIMEOUT - 1)) begin
                    w_err_nxt    = 1'b1;
                    w_state_nxt  = IDLE;
                end else begin
                    w_tmr_nxt    = r_tmr + TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any run without done or err.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_k        <= '0;
            r_tmr      <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_result   <= '0;
            r_pe_start <= 1'b0;
            r_pe_valid <= 1'b0;
            r_pe_last  <= 1'b0;
            r_pe_a     <= '0;
            r_pe_b     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_k        <= w_k_nxt;
            r_tmr      <= w_tmr_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_result   <= w_result_nxt;
            r_pe_start <= w_pe_start_nxt;
            r_pe_valid <= w_pe_valid_nxt;
            r_pe_last  <= w_pe_last_nxt;
            r_pe_a     <= w_pe_a_nxt;
            r_pe_b     <= w_pe_b_nxt;
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign err         = r_err;
    assign result      = r_result;
    assign pe_start    = r_pe_start;
    assign pe_valid_in = r_pe_valid;
    assign pe_last     = r_pe_last;
    assign pe_a        = r_pe_a;
    assign pe_b        = r_pe_b;

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Bench for pe_operand_feeder: a behavioural PE (integer-valued FP32
// operands, configurable response latency) and a cycle-level expectation of
// the framing derived from go timing, shadow buffers and the run length.
module tb_pe_operand_feeder;
    import pe_feeder_pkg::*;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        clr_n;
    logic        wr_en;
    logic        wr_sel;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  k_len;
    logic        go;
    logic        busy, done, err;
    logic [31:0] result;
    logic        pe_start, pe_valid_in, pe_last;
    logic [31:0] pe_a, pe_b, pe_c;
    logic        pe_output_valid;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] shA [16];
    logic [31:0] shB [16];
    logic [31:0] model_result = 32'h0;

    // behavioural PE
    int          pe_lat = 1;
    int          pe_due = 0;
    int          pe_acc = 0;
    logic        pe_ov_m = 1'b0;
    logic [31:0] pe_c_m = 32'h0;
    logic        spur = 1'b0;
    logic [31:0] spur_c = 32'h0;

    assign pe_output_valid = pe_ov_m | spur;
    assign pe_c            = spur ? spur_c : pe_c_m;

    pe_operand_feeder #(
        .DATA_WIDTH (32),
        .ACC_WIDTH  (32),
        .MAX_K      (16),
        .ADDR_W     (4),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk             (clk),
        .clr_n           (clr_n),
        .wr_en           (wr_en),
        .wr_sel          (wr_sel),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .k_len           (k_len),
        .go              (go),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .result          (result),
        .pe_start        (pe_start),
        .pe_valid_in     (pe_valid_in),
        .pe_last         (pe_last),
        .pe_a            (pe_a),
        .pe_b            (pe_b),
        .pe_c            (pe_c),
        .pe_output_valid (pe_output_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] int_to_fp32(input int n);
        int e;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        e = 0;
        for (int i = 0; i < 24; i++) if (n >= (1 << i)) e = i;
        m = 32'(n) << (23 - e);
        return {1'b0, 8'(127 + e), m[22:0]};
    endfunction

    function automatic int fp32_to_int(input logic [31:0] f);
        int e;
        logic [31:0] m;
        if (f[30:0] == 31'h0) return 0;
        e = int'(f[30:23]) - 127;
        m = {8'h01, f[22:0]};
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [31:0] rand_op();
        return int_to_fp32(int'($urandom_range(0, 15)));
    endfunction

    // PE accumulates on observed beats and answers pe_lat cycles after the last one
    always @(negedge clk) begin
        if (!clr_n) begin
            pe_due  <= 0;
            pe_ov_m <= 1'b0;
        end else begin
            pe_ov_m <= 1'b0;
            if (pe_valid_in) begin
                pe_acc <= (pe_start ? 0 : pe_acc) + fp32_to_int(pe_a) * fp32_to_int(pe_b);
                if (pe_last) pe_due <= pe_lat;
            end else if (pe_due > 0) begin
                pe_due <= pe_due - 1;
                if (pe_due == 1) begin
                    pe_ov_m <= 1'b1;
                    pe_c_m  <= int_to_fp32(pe_acc);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic sel, input int addr, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 4'(addr);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        if (!sel) shA[addr] = d;
        else      shB[addr] = d;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        chk("idle_done", done, 0);
        chk("idle_err", err, 0);
        chk("idle_busy", busy, 0);
        chk("idle_vld", pe_valid_in, 0);
    endtask

    // Called at a negedge with the DUT idle: that cycle is T (go sampled at its end).
    // Returns at the negedge of the done/err cycle.
    task automatic run(input int k, input int lat, input logic hold,
                       input logic wr_same, input logic junk_wr);
        int          sum;
        int          nwait;
        int          addr;
        logic [31:0] exp_res;
        pe_lat = lat;
        k_len  = 5'(k);
        go     = 1'b1;
        wr_en  = 1'b0;
        if (wr_same) begin
            addr    = $urandom_range(0, k - 1);
            wr_sel  = 1'($urandom_range(0, 1));
            wr_addr = 4'(addr);
            wr_data = rand_op();
            wr_en   = 1'b1;
            if (!wr_sel) shA[addr] = wr_data;
            else         shB[addr] = wr_data;
        end
        sum = 0;
        for (int i = 0; i < k; i++) sum += fp32_to_int(shA[i]) * fp32_to_int(shB[i]);
        exp_res = (lat == 0) ? model_result : int_to_fp32(sum);
        @(negedge clk);
        if (!hold) go = 1'b0;
        for (int i = 0; i < k; i++) begin
            wr_en = junk_wr;
            if (junk_wr) begin
                wr_sel  = 1'($urandom_range(0, 1));
                wr_addr = 4'($urandom_range(0, 15));
                wr_data = $urandom;
            end
            chk($sformatf("k%0d_beat%0d_vld", k, i), pe_valid_in, 1);
            chk($sformatf("k%0d_beat%0d_start", k, i), pe_start, (i == 0) ? 1 : 0);
            chk($sformatf("k%0d_beat%0d_last", k, i), pe_last, (i == k - 1) ? 1 : 0);
            chk($sformatf("k%0d_beat%0d_a", k, i), pe_a, shA[i]);
            chk($sformatf("k%0d_beat%0d_b", k, i), pe_b, shB[i]);
            chk($sformatf("k%0d_beat%0d_busy", k, i), busy, 1);
            chk($sformatf("k%0d_beat%0d_done", k, i), done, 0);
            @(negedge clk);
        end
        wr_en = 1'b0;
        nwait = (lat == 0) ? TIMEOUT : lat;
        for (int c = 0; c < nwait; c++) begin
            chk($sformatf("k%0d_wait%0d_vld", k, c), pe_valid_in, 0);
            chk($sformatf("k%0d_wait%0d_ab", k, c), pe_a | pe_b, 0);
            chk($sformatf("k%0d_wait%0d_busy", k, c), busy, 1);
            chk($sformatf("k%0d_wait%0d_de", k, c), {done, err}, 0);
            @(negedge clk);
        end
        chk($sformatf("k%0d_end_done", k), done, (lat != 0) ? 1 : 0);
        chk($sformatf("k%0d_end_err", k), err, (lat == 0) ? 1 : 0);
        chk($sformatf("k%0d_end_busy", k), busy, 0);
        chk($sformatf("k%0d_end_vld", k), pe_valid_in, 0);
        chk($sformatf("k%0d_end_result", k), result, exp_res);
        if (lat != 0) model_result = exp_res;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=no_finish exp=finish");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        logic prev_hold;
        int   k, lat;
        logic hold;
        go = 0; wr_en = 0; wr_sel = 0; wr_addr = 0; wr_data = 0; k_len = 0;
        clr_n = 1'b1;
        #1 clr_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_result", result, 0);
        chk("rst_ctl", {pe_start, pe_valid_in, pe_last}, 0);
        chk("rst_a", pe_a, 0);
        chk("rst_b", pe_b, 0);
        clr_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            wr(1'b0, i, rand_op());
            wr(1'b1, i, rand_op());
        end

        // dot product k=4
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, i, int_to_fp32(i + 1));
            wr(1'b1, i, FP32_ONE);
        end
        run(4, 1, 1'b0, 1'b0, 1'b0);
        chk("dot4_const", result, 32'h4120_0000);
        idle_cycle();

        // single element
        wr(1'b0, 0, 32'h4040_0000);
        wr(1'b1, 0, 32'h4000_0000);
        run(1, 1, 1'b0, 1'b0, 1'b0);
        chk("k1_const", result, 32'h40C0_0000);
        idle_cycle();

        // back-to-back with go held through done
        run(2, 1, 1'b1, 1'b0, 1'b0);
        run(2, 2, 1'b0, 1'b0, 1'b0);
        idle_cycle();

        // illegal lengths
        for (int j = 0; j < 3; j++) begin
            k_len = (j == 0) ? 5'd0 : (j == 1) ? 5'd17 : 5'd31;
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            chk($sformatf("ill%0d_err", j), err, 1);
            chk($sformatf("ill%0d_busy", j), busy, 0);
            chk($sformatf("ill%0d_vld", j), pe_valid_in, 0);
            chk($sformatf("ill%0d_done", j), done, 0);
            @(negedge clk);
            chk($sformatf("ill%0d_err_drop", j), err, 0);
            chk($sformatf("ill%0d_busy2", j), busy, 0);
        end

        // pe_output_valid while idle is ignored
        spur   = 1'b1;
        spur_c = 32'hDEAD_BEEF;
        @(negedge clk);
        spur   = 1'b0;
        chk("spur_done", done, 0);
        chk("spur_result", result, model_result);

        // timeout, then a fresh run with new writes; then slowest legal response
        run(3, 0, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        for (int i = 0; i < 3; i++) wr(1'b0, i, rand_op());
        run(3, 1, 1'b0, 1'b0, 1'b1);
        idle_cycle();
        run(2, TIMEOUT, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        run(16, 1, 1'b0, 1'b1, 1'b1);
        idle_cycle();

        // reset during beat 2 of a k=8 run
        k_len = 5'd8;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_pre_vld", pe_valid_in, 1);
        chk("mid_pre_a", pe_a, shA[2]);
        #2 clr_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_ctl", {pe_start, pe_valid_in, pe_last}, 0);
        chk("mid_ab", pe_a | pe_b, 0);
        chk("mid_de", {done, err}, 0);
        chk("mid_result", result, 0);
        @(negedge clk);
        clr_n = 1'b1;
        model_result = 32'h0;
        for (int c = 0; c < TIMEOUT + 4; c++) begin
            @(negedge clk);
            chk("post_rst_de", {done, err}, 0);
            chk("post_rst_busy", busy, 0);
        end
        run(8, 1, 1'b0, 1'b0, 1'b0);
        idle_cycle();

        // randomized runs
        prev_hold = 1'b0;
        for (int it = 0; it < 24; it++) begin
            if (!prev_hold) begin
                repeat ($urandom_range(0, 6))
                    wr(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), rand_op());
            end
            k    = $urandom_range(1, 16);
            lat  = ($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(1, 4));
            hold = (it != 23) && ($urandom_range(0, 3) == 0);
            run(k, lat, hold, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (!hold) idle_cycle();
            prev_hold = hold;
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
